instr_fetch_unit: RTL

- Fetch stage directly upstream of the instruction register.
- Owns the program counter and fetches 16-bit instruction words from instruction memory over a req/ack handshake.
- Buffers fetched words in a 2-entry prefetch FIFO and presents them to the instruction register with a valid/ready handshake; the IR load strobe is `ir_valid & ir_ready`.
- Supports PC redirect (branch/jump) and halt from the control unit.

---
 rtl/instr_fetch_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches 16-bit words over req/ack into a 2-entry
// prefetch FIFO feeding the IR. Optional stall counter under IFETCH_PERF_EN.
module instr_fetch_unit #(
   parameter int            AW       = 8,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [15:0]   imem_rdata,
   output logic          ir_valid,
   output logic [15:0]   ir_data,
   output logic [AW-1:0] ir_pc,
   input  logic          ir_ready,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_pc,
   input  logic          halt
`ifdef IFETCH_PERF_EN
   ,
   output logic [15:0]   stall_cycles
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT, DROP, HALTED} state_t;

   state_t        state, state_nx;
   logic          req_nx;
   logic [AW-1:0] addr_nx;
   logic [AW-1:0] fetch_pc, fetch_pc_nx;

   logic [1:0]    count;
   logic [1:0]    count_after_pop;
   logic          rd_ptr, wr_ptr;
   logic [15:0]   fifo_data [2];
   logic [AW-1:0] fifo_pc   [2];
   logic          push, pop;

   // Handshakes: a memory word transfers on any cycle with imem_req & imem_ack,
   // and imem_addr is held while imem_req is high. The FIFO head transfers to
   // the IR on any cycle with ir_valid & ir_ready; the head is held otherwise.
   assign ir_valid = (count != 2'd0);
   assign ir_data  = fifo_data[rd_ptr];
   assign ir_pc    = fifo_pc[rd_ptr];

   // A redirect flushes the FIFO, so a same-cycle pop must not advance anything.
   assign pop             = ir_valid & ir_ready & ~redirect;
   assign count_after_pop = count - {1'b0, pop};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         fetch_pc  <= RESET_PC;
      end else begin
         state     <= state_nx;
         imem_req  <= req_nx;
         imem_addr <= addr_nx;
         fetch_pc  <= fetch_pc_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      req_nx      = imem_req;
      addr_nx     = imem_addr;
      fetch_pc_nx = fetch_pc;
      push        = 1'b0;
      case (state)
         IDLE: begin
            if (redirect) fetch_pc_nx = redirect_pc;
            if (halt) begin
               state_nx = HALTED;
            end else if (redirect || count_after_pop != 2'd2) begin
               // A redirect empties the FIFO, so a slot is always free then.
               state_nx = WAIT;
               req_nx   = 1'b1;
               addr_nx  = redirect ? redirect_pc : fetch_pc;
            end
         end
         WAIT: begin
            if (redirect) begin
               fetch_pc_nx = redirect_pc;
               if (imem_ack) begin
                  state_nx = IDLE;
                  req_nx   = 1'b0;
               end else begin
                  state_nx = DROP;
               end
            end else if (imem_ack) begin
               push        = 1'b1;
               fetch_pc_nx = imem_addr + AW'(1);
               // After push/pop a slot remains only if the FIFO was otherwise empty.
               if (count_after_pop == 2'd0 && !halt) begin
                  addr_nx = imem_addr + AW'(1);
               end else begin
                  req_nx   = 1'b0;
                  state_nx = halt ? HALTED : IDLE;
               end
            end
         end
         DROP: begin
            if (redirect) fetch_pc_nx = redirect_pc;
            if (imem_ack) begin
               state_nx = IDLE;
               req_nx   = 1'b0;
            end
         end
         HALTED: begin
            if (redirect) fetch_pc_nx = redirect_pc;
            if (!halt) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_data[i] <= '0;
            fifo_pc[i]   <= '0;
         end
      end else if (redirect) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= imem_addr;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

`ifdef IFETCH_PERF_EN
   // Cycles where the IR wanted an instruction but none was ready; saturating.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= 16'd0;
      end else if (ir_ready && !ir_valid && stall_cycles != 16'hFFFF) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif

endmodule
